// File: rtl/kb_pkg.sv
// +-----------------------------------------------------------------+
// | kb_pkg : shared FSM states and frame constants for kb_frame_rx  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

package kb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      CHECK = 2'd2
   } kb_state_t;

   // start + 8 data + parity + stop
   localparam int FRAME_LEN       = 11;
   localparam int TIMEOUT_DEFAULT = 100000;

   function automatic logic odd_parity_ok(input logic [8:0] data_and_parity);
      return ^data_and_parity;
   endfunction

endpackage

`default_nettype wire

// File: rtl/kb_edge_detect.sv
// +-----------------------------------------------------------------+
// | kb_edge_detect : single-cycle pulse on a 1->0 transition of sig |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

module kb_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic sig,
   output logic fall_pulse
);

   logic sig_prev;

   // Reset to 1 so a line that idles high never yields a spurious edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         sig_prev <= 1'b1;
      end else begin
         sig_prev <= sig;
      end
   end

   assign fall_pulse = sig_prev & ~sig;

endmodule

`default_nettype wire

// File: rtl/kb_frame_rx.sv
// +-----------------------------------------------------------------+
// | kb_frame_rx : PS/2 keyboard frame receiver with parity, stop    |
// |               and inter-edge timeout checking                   |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

module kb_frame_rx
   import kb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       kb_clk_sync,
   input  logic       kb_data_sync,
   output logic [7:0] scan_code,
   output logic       scan_valid,
   output logic       parity_err,
   output logic       frame_err,
   output logic       busy
);

   localparam int SHIFT_BITS = FRAME_LEN - 1;
   localparam int TO_W       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]      LAST_BIT = 4'(SHIFT_BITS - 1);

   kb_state_t                 state;
   kb_state_t                 next_state;
   logic                      fall;
   logic [SHIFT_BITS-1:0]     shreg;
   logic [3:0]                bit_cnt;
   logic [TO_W-1:0]           to_cnt;
   logic                      start_frame;
   logic                      shift_en;
   logic                      timeout_hit;

   kb_edge_detect u_edge (
      .clk        (clk),
      .rst        (rst),
      .sig        (kb_clk_sync),
      .fall_pulse (fall)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state  = state;
      start_frame = 1'b0;
      shift_en    = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         IDLE: begin
            if (fall && !kb_data_sync) begin
               next_state  = RECV;
               start_frame = 1'b1;
            end
         end
         RECV: begin
            // An edge wins over a simultaneous timeout expiry.
            if (fall) begin
               shift_en = 1'b1;
               if (bit_cnt == LAST_BIT) begin
                  next_state = CHECK;
               end
            end else if (to_cnt == TO_LAST) begin
               timeout_hit = 1'b1;
               next_state  = IDLE;
            end
         end
         CHECK: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shreg      <= '0;
         bit_cnt    <= '0;
         to_cnt     <= '0;
         scan_code  <= 8'h00;
         scan_valid <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         scan_valid <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;

         if (start_frame) begin
            bit_cnt <= '0;
            to_cnt  <= '0;
         end else if (shift_en) begin
            // LSB-first: after ten shifts shreg[7:0]=data, [8]=parity, [9]=stop.
            shreg   <= {kb_data_sync, shreg[SHIFT_BITS-1:1]};
            bit_cnt <= bit_cnt + 4'd1;
            to_cnt  <= '0;
         end else if (timeout_hit) begin
            to_cnt    <= '0;
            frame_err <= 1'b1;
         end else if (state == RECV) begin
            to_cnt <= to_cnt + TO_W'(1);
         end

         if (state == CHECK) begin
            if (!shreg[9]) begin
               frame_err <= 1'b1;
            end else if (!odd_parity_ok(shreg[8:0])) begin
               parity_err <= 1'b1;
            end else begin
               scan_valid <= 1'b1;
               scan_code  <= shreg[7:0];
            end
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_kb_frame_rx.sv
// +-----------------------------------------------------------------+
// | tb_kb_frame_rx : directed vector bench for kb_frame_rx          |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

module tb_kb_frame_rx;

   localparam int TO = 64;
   localparam int H  = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       kb_clk_sync = 1'b1;
   logic       kb_data_sync = 1'b1;
   logic [7:0] scan_code;
   logic       scan_valid;
   logic       parity_err;
   logic       frame_err;
   logic       busy;

   kb_frame_rx #(.TIMEOUT_CYCLES(TO)) dut (
      .clk          (clk),
      .rst          (rst),
      .kb_clk_sync  (kb_clk_sync),
      .kb_data_sync (kb_data_sync),
      .scan_code    (scan_code),
      .scan_valid   (scan_valid),
      .parity_err   (parity_err),
      .frame_err    (frame_err),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         n_valid = 0, n_perr = 0, n_ferr = 0, viol = 0;
   int         last_valid_cyc = -1, last_ferr_cyc = -1;
   logic [7:0] last_code = 8'h00;
   logic       pv = 1'b0, pp = 1'b0, pf = 1'b0;

   always @(negedge clk) begin
      if (scan_valid) begin
         n_valid++;
         last_code      = scan_code;
         last_valid_cyc = cyc;
      end
      if (parity_err) n_perr++;
      if (frame_err) begin
         n_ferr++;
         last_ferr_cyc = cyc;
      end
      if ((int'(scan_valid) + int'(parity_err) + int'(frame_err)) > 1) viol++;
      if ((scan_valid && pv) || (parity_err && pp) || (frame_err && pf)) viol++;
      pv = scan_valid;
      pp = parity_err;
      pf = frame_err;
   end

   int tests = 0, failed = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [10:0] mk(input logic [7:0] d, input logic p, input logic s);
      return {s, p, d, 1'b0};
   endfunction

   // Drives bits[0..n-1] LSB first; returns cycle in which the last falling edge is seen.
   task automatic send_bits(input logic [10:0] bits, input int n, output int last_edge);
      last_edge = -1;
      for (int i = 0; i < n; i++) begin
         kb_data_sync = bits[i];
         repeat (H) tick();
         kb_clk_sync = 1'b0;
         last_edge   = cyc;
         repeat (H) tick();
         kb_clk_sync = 1'b1;
      end
      kb_data_sync = 1'b1;
   endtask

   typedef struct {
      logic [7:0] data;
      logic       par;
      logic       stp;
      logic [7:0] exp_code;
      int         exp_v;
      int         exp_p;
      int         exp_f;
   } vec_t;

   vec_t vecs[8];

   initial begin : main
      int sv, sp, sf, le, le2;

      vecs[0] = '{8'h1C, 1'b1, 1'b1, 8'h00, 0, 1, 0};
      vecs[1] = '{8'h1C, 1'b0, 1'b1, 8'h1C, 1, 0, 0};
      vecs[2] = '{8'hF0, 1'b1, 1'b0, 8'h1C, 0, 0, 1};
      vecs[3] = '{8'hF0, 1'b1, 1'b1, 8'hF0, 1, 0, 0};
      vecs[4] = '{8'h1C, 1'b1, 1'b0, 8'hF0, 0, 0, 1};
      vecs[5] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1, 0, 0};
      vecs[6] = '{8'h55, 1'b0, 1'b1, 8'hFF, 0, 1, 0};
      vecs[7] = '{8'h00, 1'b1, 1'b1, 8'h00, 1, 0, 0};

      rst = 1'b1;
      repeat (3) tick();
      check("reset scan_code", 32'(scan_code), 32'h00);
      check("reset busy", 32'(busy), 0);
      check("reset pulses", 32'({scan_valid, parity_err, frame_err}), 0);
      rst = 1'b0;
      repeat (4) tick();

      for (int i = 0; i < 8; i++) begin
         sv = n_valid; sp = n_perr; sf = n_ferr;
         send_bits(mk(vecs[i].data, vecs[i].par, vecs[i].stp), 11, le);
         repeat (4) tick();
         check($sformatf("vec%0d scan_valid count", i), 32'(n_valid - sv), 32'(vecs[i].exp_v));
         check($sformatf("vec%0d parity_err count", i), 32'(n_perr - sp), 32'(vecs[i].exp_p));
         check($sformatf("vec%0d frame_err count", i), 32'(n_ferr - sf), 32'(vecs[i].exp_f));
         check($sformatf("vec%0d scan_code", i), 32'(scan_code), 32'(vecs[i].exp_code));
         check($sformatf("vec%0d busy after", i), 32'(busy), 0);
         if (vecs[i].exp_v == 1)
            check($sformatf("vec%0d latency", i), 32'(last_valid_cyc), 32'(le + 2));
      end

      // Timeout: start + 5 data bits, then kb_clk stays high
      sv = n_valid; sf = n_ferr;
      send_bits(mk(8'h29, 1'b0, 1'b1), 6, le);
      check("timeout busy mid-frame", 32'(busy), 1);
      for (int k = 0; k < TO + 20 && n_ferr == sf; k++) tick();
      repeat (5) tick();
      check("timeout frame_err count", 32'(n_ferr - sf), 1);
      check("timeout frame_err cycle", 32'(last_ferr_cyc), 32'(le + TO + 1));
      check("timeout no scan_valid", 32'(n_valid - sv), 0);
      check("timeout busy after", 32'(busy), 0);
      sv = n_valid;
      send_bits(mk(8'h29, 1'b0, 1'b1), 11, le);
      repeat (4) tick();
      check("after timeout valid count", 32'(n_valid - sv), 1);
      check("after timeout scan_code", 32'(scan_code), 32'h29);

      // Reset after the 4th data bit
      sv = n_valid; sp = n_perr; sf = n_ferr;
      send_bits(mk(8'hF0, 1'b1, 1'b1), 5, le);
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      repeat (TO + 10) tick();
      check("mid reset pulses", 32'((n_valid - sv) + (n_perr - sp) + (n_ferr - sf)), 0);
      check("mid reset scan_code", 32'(scan_code), 32'h00);
      check("mid reset busy", 32'(busy), 0);
      send_bits(mk(8'h1C, 1'b0, 1'b1), 11, le);
      repeat (4) tick();
      check("after reset valid count", 32'(n_valid - sv), 1);
      check("after reset scan_code", 32'(scan_code), 32'h1C);

      // Back-to-back frames with no idle time between them
      sv = n_valid;
      send_bits(mk(8'hF0, 1'b1, 1'b1), 11, le);
      check("b2b first valid count", 32'(n_valid - sv), 1);
      check("b2b first code", 32'(last_code), 32'hF0);
      check("b2b first latency", 32'(last_valid_cyc), 32'(le + 2));
      send_bits(mk(8'h1C, 1'b0, 1'b1), 11, le2);
      repeat (4) tick();
      check("b2b second valid count", 32'(n_valid - sv), 2);
      check("b2b second code", 32'(scan_code), 32'h1C);
      check("b2b second latency", 32'(last_valid_cyc), 32'(le2 + 2));

      check("pulse exclusivity/width violations", 32'(viol), 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire

// File: doc/kb_frame_rx.md
KB_FRAME_RX -- requirements
Module: kb_frame_rx

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000, giving the maximum clk cycles allowed between kb_clk falling edges inside a frame (1 ms at 100 MHz).
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous to clk and active-high.
REQ-004 SHALL have port kb_clk_sync  input  1  keyboard clock, already two-flop synchronised to clk.
REQ-005 SHALL have port kb_data_sync  input  1  keyboard data, already two-flop synchronised to clk.
REQ-006 SHALL have port scan_code  output  8  last correctly received byte; holds its value between frames.
REQ-007 SHALL have port scan_valid  output  1  one-cycle pulse; scan_code updated in the same cycle.
REQ-008 SHALL have port parity_err  output  1  one-cycle pulse on a frame with bad odd parity.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse on a bad stop bit or an inter-edge timeout.
REQ-010 SHALL have port busy  output  1  high while state is not IDLE.

Function
REQ-011 SHALL detect a falling edge as previous kb_clk_sync = 1 and current = 0, using one registered copy of kb_clk_sync; kb_data_sync SHALL be sampled in the same cycle the edge is detected.
REQ-012 SHALL implement an FSM with states IDLE, RECV and CHECK.
REQ-013 In IDLE, a falling edge with data 0 (start bit) SHALL move to RECV with bit counter = 0 and timeout counter = 0; a falling edge with data 1 SHALL be ignored with no error and no state change.
REQ-014 In RECV, each falling edge SHALL shift data into a 10-bit register LSB-first (8 data, parity, stop) and increment the bit counter; the edge that captures the 10th bit SHALL move the FSM to CHECK.
REQ-015 In RECV, the timeout counter SHALL clear on every falling edge and otherwise increment; on reaching TIMEOUT_CYCLES-1 with no edge, frame_err SHALL pulse and the FSM SHALL return to IDLE, discarding the partial frame.
REQ-016 An edge and timeout expiry in the same cycle SHALL be resolved in favour of the edge.
REQ-017 CHECK SHALL last exactly one cycle and then return to IDLE; outputs SHALL be registered so that the pulse appears in the cycle after CHECK.
REQ-018 CHECK priority: if stop bit = 0, frame_err pulses; else if the XOR of the 8 data bits and the parity bit = 0, parity_err pulses; else scan_valid pulses and scan_code loads the data byte.
REQ-019 Latency: scan_valid SHALL be high exactly 2 clk cycles after the cycle in which the stop-bit falling edge is detected.
REQ-020 At most one of scan_valid, parity_err and frame_err SHALL be high in any cycle; all three SHALL be single-cycle pulses.
REQ-021 Falling edges during CHECK SHALL be ignored; back-to-back frames SHALL be accepted when the next start edge arrives in IDLE.

Reset
REQ-022 When rst = 1, the FSM SHALL go to IDLE; the shift register, bit counter, timeout counter and edge register (set to 1) SHALL clear; scan_code SHALL be 0x00; scan_valid, parity_err, frame_err and busy SHALL be 0.
REQ-023 Asserting rst in mid-frame SHALL abort the frame without any error pulse; the first valid start edge after rst is released SHALL begin a new frame.

Structure
REQ-024 The FSM state enum (IDLE/RECV/CHECK), the frame length constant (11) and the timeout default SHALL be placed in shared package kb_pkg.
REQ-025 Falling-edge detection SHALL be a separate sub-module kb_edge_detect (inputs clk, rst, sig; output fall_pulse).
REQ-026 The timeout counter width SHALL be $clog2(TIMEOUT_CYCLES).

Verification
REQ-027 Frame with byte 0x1C and parity 0, stop 1 -> one scan_valid pulse, scan_code = 0x1C, no error pulses, busy low afterwards.
REQ-028 Frame with byte 0x1C and parity 1 -> parity_err pulse, scan_code unchanged (0x00 after reset), no scan_valid.
REQ-029 Frame with byte 0xF0, parity 1, stop 0 -> frame_err only; a following correct frame with 0xF0 -> scan_valid, scan_code = 0xF0.
REQ-030 Start bit plus 5 data bits, then kb_clk held high for TIMEOUT_CYCLES cycles -> one frame_err pulse, back in IDLE; a following correct frame with 0x29 -> scan_code = 0x29.
REQ-031 rst pulsed after the 4th data bit -> no pulses, outputs at reset values; a following correct frame with 0x1C -> scan_valid with 0x1C.
REQ-032 Back-to-back frames 0xF0 then 0x1C with minimum idle gap -> two scan_valid pulses carrying 0xF0 then 0x1C, each exactly 2 cycles after its stop-bit edge.
